// File: rtl/pwm_ref_streamer_pkg.sv
// Shared definitions for the PWM reference streamer: FSM states, Wishbone
// constants and pwm_accelerator register offsets used by both RTL and firmware.
package pwm_ref_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam logic [3:0] WB_SEL_ALL      = 4'hF;
   localparam logic [7:0] PWM_REG_CTRL    = 8'h00;
   localparam logic [7:0] PWM_REG_CPU_REF = 8'h20;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ref_fifo.sv
// 16-bit synchronous sample FIFO with level/full/empty; head word is read
// combinationally so the popping cycle can capture it.
module ref_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [15:0]            data_i,
   output logic [15:0]            data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;

   assign full_o  = (level_q == FULL_LEVEL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push on a full FIFO is refused even if a pop frees a slot this cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/pwm_ref_streamer.sv
// Wishbone initiator that writes one queued 16-bit reference sample to a fixed
// peripheral register per trigger pulse, keeping updates aligned to the carrier.
module pwm_ref_streamer
   import pwm_ref_streamer_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = PWM_REG_CPU_REF,
   parameter int                    FIFO_DEPTH  = 16,
   parameter int                    TIMEOUT     = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        trigger,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [15:0]                 s_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [ADDR_WIDTH-1:0]       wbm_addr,
   output logic [31:0]                 wbm_dat_o,
   output logic                        wbm_we,
   output logic [3:0]                  wbm_sel,
   output logic                        wbm_cyc,
   output logic                        wbm_stb,
   input  logic                        wbm_ack,
   output logic [15:0]                 underrun_cnt,
   output logic [15:0]                 overrun_cnt,
   output logic                        err,
   input  logic                        clear_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic                    pending_q, pending_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [15:0]             under_q, under_d, over_q, over_d;
   logic [15:0]             last_q, last_d;
   logic                    err_q, err_d;
   logic                    cyc_q, cyc_d, we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             dat_q, dat_d;
   logic [3:0]              sel_q, sel_d;
   logic                    fifo_pop, fifo_full, fifo_empty, start, timeout;
   logic [15:0]             fifo_dout;

   ref_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (s_valid),
      .pop_i   (fifo_pop),
      .data_i  (s_data),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      tmo_d     = tmo_q;
      under_d   = under_q;
      over_d    = over_q;
      last_d    = last_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      addr_d    = addr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      fifo_pop  = 1'b0;
      start     = 1'b0;
      timeout   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A trigger arriving together with a pending request re-arms pending.
            if (enable && (trigger || pending_q)) begin
               start     = 1'b1;
               state_d   = ST_REQ;
               pending_d = trigger & pending_q;
            end
         end
         ST_REQ: begin
            if (wbm_ack || tmo_q == TMO_LAST) begin
               state_d = ST_GAP;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               timeout = ~wbm_ack;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (enable && trigger && state_q != ST_IDLE) begin
         if (pending_q) over_d = sat_inc16(over_q);
         else           pending_d = 1'b1;
      end

      // An empty FIFO repeats the previous reference rather than skipping the write.
      if (start) begin
         tmo_d  = '0;
         cyc_d  = 1'b1;
         we_d   = 1'b1;
         addr_d = TARGET_ADDR;
         sel_d  = WB_SEL_ALL;
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            last_d   = fifo_dout;
            dat_d    = {16'd0, fifo_dout};
         end else begin
            under_d = sat_inc16(under_q);
            dat_d   = {16'd0, last_q};
         end
      end

      if (!enable) pending_d = 1'b0;
      err_d = timeout | (err_q & ~clear_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         tmo_q     <= '0;
         under_q   <= '0;
         over_q    <= '0;
         last_q    <= '0;
         err_q     <= 1'b0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         tmo_q     <= tmo_d;
         under_q   <= under_d;
         over_q    <= over_d;
         last_q    <= last_d;
         err_q     <= err_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
      end
   end

   assign s_ready      = ~fifo_full;
   assign wbm_cyc      = cyc_q;
   assign wbm_stb      = cyc_q;
   assign wbm_we       = we_q;
   assign wbm_addr     = addr_q;
   assign wbm_dat_o    = dat_q;
   assign wbm_sel      = sel_q;
   assign underrun_cnt = under_q;
   assign overrun_cnt  = over_q;
   assign err          = err_q;

endmodule

// File: tb/tb_pwm_ref_streamer.sv
// Directed bench for pwm_ref_streamer with a one-cycle-ack Wishbone slave model.
module tb_pwm_ref_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic [4:0]  fifo_level;
   logic [7:0]  wbm_addr;
   logic [31:0] wbm_dat_o;
   logic        wbm_we;
   logic [3:0]  wbm_sel;
   logic        wbm_cyc;
   logic        wbm_stb;
   logic        wbm_ack;
   logic [15:0] underrun_cnt;
   logic [15:0] overrun_cnt;
   logic        err;
   logic        clear_err = 1'b0;

   logic        ack_en = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;

   logic [31:0] log_dat [64];
   logic [7:0]  log_addr [64];
   logic [3:0]  log_sel [64];
   int          wr_cnt = 0;
   int          stb_run = 0;
   int          stb_len = 0;
   int          rises = 0;
   logic        stb_prev = 1'b0;

   typedef struct {
      logic [15:0] sample;
      logic [31:0] exp_dat;
      logic [4:0]  exp_level;
   } vec_t;
   vec_t vecs [3];

   pwm_ref_streamer #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .trigger      (trigger),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .fifo_level   (fifo_level),
      .wbm_addr     (wbm_addr),
      .wbm_dat_o    (wbm_dat_o),
      .wbm_we       (wbm_we),
      .wbm_sel      (wbm_sel),
      .wbm_cyc      (wbm_cyc),
      .wbm_stb      (wbm_stb),
      .wbm_ack      (wbm_ack),
      .underrun_cnt (underrun_cnt),
      .overrun_cnt  (overrun_cnt),
      .err          (err),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wbm_ack <= 1'b0;
      else        wbm_ack <= ack_en & wbm_stb & wbm_cyc & ~wbm_ack;
   end

   always @(posedge clk) begin
      if (wbm_cyc && wbm_stb && wbm_ack) begin
         log_dat[wr_cnt % 64]  <= wbm_dat_o;
         log_addr[wr_cnt % 64] <= wbm_addr;
         log_sel[wr_cnt % 64]  <= wbm_sel;
         wr_cnt <= wr_cnt + 1;
      end
      if (wbm_stb) stb_run <= stb_run + 1;
      else if (stb_run != 0) begin
         stb_len <= stb_run;
         stb_run <= 0;
      end
      if (wbm_stb && !stb_prev) rises <= rises + 1;
      stb_prev <= wbm_stb;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic pulse_trig();
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   initial begin
      int wr0;
      int r0;
      vecs[0] = '{16'h1000, 32'h0000_1000, 5'd2};
      vecs[1] = '{16'h2000, 32'h0000_2000, 5'd1};
      vecs[2] = '{16'h3000, 32'h0000_3000, 5'd0};

      // Reset state
      tick(3);
      check("rst_stb", {31'd0, wbm_stb}, 32'd0);
      check("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
      check("rst_we", {31'd0, wbm_we}, 32'd0);
      check("rst_sel", {28'd0, wbm_sel}, 32'd0);
      check("rst_addr", {24'd0, wbm_addr}, 32'd0);
      check("rst_dat", wbm_dat_o, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd1);
      check("rst_level", {27'd0, fifo_level}, 32'd0);
      check("rst_under", {16'd0, underrun_cnt}, 32'd0);
      check("rst_over", {16'd0, overrun_cnt}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Basic stream, table driven
      ack_en = 1'b1;
      for (int i = 0; i < 3; i++) push(vecs[i].sample);
      check("preload_level", {27'd0, fifo_level}, 32'd3);
      enable = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         pulse_trig();
         tick(9);
         check("basic_wr_cnt", wr_cnt, i + 1);
         check("basic_dat", log_dat[i], vecs[i].exp_dat);
         check("basic_addr", {24'd0, log_addr[i]}, 32'h20);
         check("basic_sel", {28'd0, log_sel[i]}, 32'hF);
         check("basic_stb_len", stb_len, 2);
         check("basic_level", {27'd0, fifo_level}, {27'd0, vecs[i].exp_level});
      end
      check("basic_over", {16'd0, overrun_cnt}, 32'd0);

      // Underrun repeats the last sample
      pulse_trig();
      tick(9);
      check("under_wr_cnt", wr_cnt, 4);
      check("under_dat", log_dat[3], 32'h0000_3000);
      check("under_cnt", {16'd0, underrun_cnt}, 32'd1);

      // Pending and overrun: three back-to-back triggers
      for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
      wr0 = wr_cnt;
      trigger = 1'b1;
      tick(3);
      trigger = 1'b0;
      tick(20);
      check("pend_wr_cnt", wr_cnt - wr0, 2);
      check("pend_dat0", log_dat[wr0], 32'h0000_A001);
      check("pend_dat1", log_dat[wr0 + 1], 32'h0000_A002);
      check("pend_over", {16'd0, overrun_cnt}, 32'd1);
      check("pend_level", {27'd0, fifo_level}, 32'd2);
      check("pend_under", {16'd0, underrun_cnt}, 32'd1);

      // Timeout with a silent slave
      ack_en = 1'b0;
      wr0 = wr_cnt;
      pulse_trig();
      tick(15);
      check("tmo_stb_len", stb_len, 8);
      check("tmo_err", {31'd0, err}, 32'd1);
      check("tmo_no_write", wr_cnt - wr0, 0);
      check("tmo_level", {27'd0, fifo_level}, 32'd1);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("clear_err", {31'd0, err}, 32'd0);

      // clear_err coinciding with the timeout edge
      pulse_trig();
      tick(7);
      check("tmo2_stb_before", {31'd0, wbm_stb}, 32'd1);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("tmo2_stb_after", {31'd0, wbm_stb}, 32'd0);
      check("tmo2_err_priority", {31'd0, err}, 32'd1);
      tick(5);
      check("tmo2_level", {27'd0, fifo_level}, 32'd0);

      // Full FIFO
      ack_en = 1'b1;
      for (int i = 0; i < 16; i++) push(16'h5000 + 16'(i));
      check("full_s_ready", {31'd0, s_ready}, 32'd0);
      check("full_level", {27'd0, fifo_level}, 32'd16);
      push(16'hDEAD);
      check("full_level_17", {27'd0, fifo_level}, 32'd16);
      wr0 = wr_cnt;
      for (int i = 0; i < 16; i++) begin
         pulse_trig();
         tick(9);
      end
      check("drain_wr_cnt", wr_cnt - wr0, 16);
      check("drain_first", log_dat[wr0 % 64], 32'h0000_5000);
      check("drain_last", log_dat[(wr0 + 15) % 64], 32'h0000_500F);
      check("drain_level", {27'd0, fifo_level}, 32'd0);
      check("drain_under", {16'd0, underrun_cnt}, 32'd1);

      // Reset while stb is high
      push(16'h7001);
      push(16'h7002);
      ack_en = 1'b0;
      pulse_trig();
      tick(2);
      check("mid_stb_high", {31'd0, wbm_stb}, 32'd1);
      check("mid_level", {27'd0, fifo_level}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_stb", {31'd0, wbm_stb}, 32'd0);
      check("async_cyc", {31'd0, wbm_cyc}, 32'd0);
      check("async_level", {27'd0, fifo_level}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Disabled: triggers are ignored
      enable = 1'b0;
      ack_en = 1'b1;
      push(16'h7777);
      r0  = rises;
      wr0 = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         pulse_trig();
         tick(1);
      end
      tick(10);
      check("dis_no_stb", rises - r0, 0);
      check("dis_no_write", wr_cnt - wr0, 0);
      check("dis_under", {16'd0, underrun_cnt}, 32'd0);
      check("dis_over", {16'd0, overrun_cnt}, 32'd0);
      check("dis_level", {27'd0, fifo_level}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_ref_streamer.md
# pwm_ref_streamer

Wishbone initiator that streams 16-bit modulation reference samples into a register of a Wishbone peripheral, one write per trigger pulse. Its normal target is the `cpu_reference` register (offset 0x20) of `pwm_accelerator` in manual mode, with `trigger` tied to the carrier sync pulse. The CPU or a DSP block fills an internal FIFO. The block performs the bus writes so that reference updates stay aligned to the carrier, with no CPU interrupt latency.

## Interface
- `ADDR_WIDTH`, 8, width of `wbm_addr`
- `TARGET_ADDR`, 8'h20, byte address written on every transaction
- `FIFO_DEPTH`, 16, sample FIFO depth; must be a power of two, at least 2
- `TIMEOUT`, 255, maximum number of cycles `wbm_stb` may stay high without `wbm_ack`
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: when low, triggers are ignored
- `trigger` in 1: one-cycle pulse that requests the next sample write
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 16: sample push handshake
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy
- `wbm_addr` out ADDR_WIDTH, `wbm_dat_o` out 32, `wbm_we` out 1, `wbm_sel` out 4, `wbm_cyc` out 1, `wbm_stb` out 1, `wbm_ack` in 1: Wishbone master
- `underrun_cnt` out 16: saturating count of triggers that found the FIFO empty
- `overrun_cnt` out 16: saturating count of triggers that were dropped
- `err` out 1: sticky bus-timeout flag
- `clear_err` in 1: clears `err`

## Operation
- **Reset values:** all Wishbone outputs are 0. `s_ready`=1, `fifo_level`=0, both counters 0, `err`=0, pending flag 0, `last_sample`=0, state IDLE.
- **Sample push:** a sample is accepted when `s_valid && s_ready`. `s_ready` = !full and is independent of `enable`, so the FIFO can be preloaded. A push on a full FIFO is not accepted, even if a pop happens in the same cycle. A push and a pop in the same cycle on a non-full, non-empty FIFO leave the level unchanged.
- **Trigger handling:**
  - Trigger accepted only when `enable`=1.
  - In IDLE: start a transaction.
  - In any other state: set `pending`. If `pending` is already set, drop the trigger and increment `overrun_cnt`.
- **Transaction start:**
  - If the FIFO is not empty: pop the sample and load it into `last_sample`.
  - If the FIFO is empty: reuse `last_sample` and increment `underrun_cnt`.
  - Drive `wbm_dat_o`={16'd0, sample}, `wbm_addr`=TARGET_ADDR, `wbm_we`=1, `wbm_sel`=4'hF, `wbm_cyc`=`wbm_stb`=1.
- **FSM states:**
  - IDLE → REQ on a trigger, or on `pending` when `enable`=1 (consumes `pending`).
  - REQ holds all outputs stable until `wbm_ack`=1 is sampled. It then drops `cyc`, `stb` and `we` on that same edge and goes to GAP.
  - REQ → GAP also when the timeout counter reaches TIMEOUT without an ack. This drops the bus, sets `err`, and the sample counts as consumed.
  - GAP lasts exactly one cycle with `stb`=0 (lets a one-cycle-ack slave clear its ack), then → IDLE.
- **`enable` falling mid-transaction:** the current REQ completes or times out normally. `pending` is cleared. FIFO contents are kept.
- **`clear_err` and timeout in the same cycle:** setting `err` has priority.
- **Counters:** saturate at 16'hFFFF and are cleared only by reset.
- **Reset mid-transaction:** `stb` and `cyc` drop asynchronously. The FIFO is emptied.

## Timing
- Trigger at edge N (IDLE) → `stb`/`cyc` high from edge N+1. The registered pop also happens at N+1.
- Against a slave that acks one cycle after `stb` (ack registered at N+2): `stb` falls at N+3, GAP covers N+3..N+4, IDLE at N+4.
- Minimum trigger-to-trigger spacing without setting `pending`: 4 cycles.
- The timeout counter starts at 0 on entering REQ. With TIMEOUT=255 and no ack, `stb` falls exactly 255 cycles after it rose.
- `fifo_level` and `s_ready` update on the edge after a push or pop.

## Structure
- **Shared package:** state enum (IDLE, REQ, GAP), `WB_SEL_ALL`=4'hF, and the `pwm_accelerator` register offsets (CTRL 0x00, CPU_REF 0x20), so firmware headers and RTL share one source.
- **Sub-module:** `ref_fifo`, a synchronous FIFO (16-bit wide, FIFO_DEPTH deep) with full/empty/level outputs.
- The FSM, pending flag, counters and timeout logic live in the top module.

## Test plan
- **Basic stream:** preload 3 samples 0x1000/0x2000/0x3000, enable, 3 triggers spaced 10 cycles apart → 3 writes to 0x20 with data 0x00001000, 0x00002000, 0x00003000 and `sel`=F. Each `stb` lasts 2 cycles; `fifo_level` ends at 0.
- **Underrun:** after the basic stream, send a trigger with the FIFO empty → write of 0x00003000, `underrun_cnt`=1.
- **Pending and overrun:** 3 triggers on consecutive cycles with 4 samples queued → 2 writes back-to-back with one GAP cycle between them, `overrun_cnt`=1, `fifo_level`=2.
- **Timeout:** slave never acks, TIMEOUT=8 → `stb` high for exactly 8 cycles, `err`=1. Pulsing `clear_err` then clears `err`. Pulsing `clear_err` in the timeout cycle leaves `err`=1.
- **Full FIFO:** push FIFO_DEPTH+1 samples with no triggers → `s_ready`=0 after the 16th push, the 17th sample is rejected, `fifo_level`=16.
- **Reset and disable mid-transaction:** assert `rst_n` low while `stb`=1 → `stb`/`cyc` go to 0 immediately, `fifo_level`=0. With `enable`=0, triggers produce no bus activity and the counters do not change.
